// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI target-side shift engine. SCK/NSS/MOSI are oversampled in clk_i.
package spi_slave_core_pkg;
   localparam int unsigned SPI_DATA_WIDTH = 32;
   localparam int unsigned BIT_CNT_W      = 6;
   localparam int unsigned IDX_W          = 5;
endpackage

module spi_slave_core
   import spi_slave_core_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      en_i,
   input  logic                      cpol_i,
   input  logic                      cpha_i,
   input  logic                      lsb_i,
   input  logic [1:0]                dtb_i,
   input  logic                      tx_valid_i,
   output logic                      tx_ready_o,
   input  logic [SPI_DATA_WIDTH-1:0] tx_data_i,
   output logic                      rx_valid_o,
   input  logic                      rx_ready_i,
   output logic [SPI_DATA_WIDTH-1:0] rx_data_o,
   output logic                      busy_o,
   output logic                      ovr_o,
   output logic                      udr_o,
   input  logic                      spi_sck_i,
   input  logic                      spi_nss_i,
   input  logic                      spi_mosi_i,
   output logic                      spi_miso_o,
   output logic                      spi_miso_oe_o
);

   logic [SYNC_STAGES-1:0]    sck_sync, nss_sync, mosi_sync;
   logic                      sck_d, nss_d;
   logic                      sck_rise_q, sck_fall_q, nss_rise_q, nss_fall_q, mosi_q;

   logic                      cpol_q, cpha_q, lsb_q;
   logic [1:0]                dtb_q;
   logic [BIT_CNT_W-1:0]      bit_cnt, bit_cnt_n;
   logic [SPI_DATA_WIDTH-1:0] tx_sh, tx_sh_n, rx_sh, rx_sh_n;
   logic [SPI_DATA_WIDTH-1:0] tx_buf, tx_buf_n, rx_data_n, rx_mask;
   logic                      tx_ready_n, rx_valid_n, busy_n, ovr_n, udr_n, miso_n;
   logic                      load_req;

   logic                      start, abort, lead, trail, sample_edge, shift_edge;
   logic                      lsb_c;
   logic [1:0]                dtb_c;
   logic [BIT_CNT_W-1:0]      n_bits;

   // Synchronizers plus one registered edge-detect stage; MOSI delayed to stay aligned with SCK
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sck_sync   <= '0;
         nss_sync   <= '0;
         mosi_sync  <= '0;
         sck_d      <= 1'b0;
         nss_d      <= 1'b0;
         sck_rise_q <= 1'b0;
         sck_fall_q <= 1'b0;
         nss_rise_q <= 1'b0;
         nss_fall_q <= 1'b0;
         mosi_q     <= 1'b0;
      end else begin
         sck_sync   <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
         nss_sync   <= {nss_sync[SYNC_STAGES-2:0], spi_nss_i};
         mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
         sck_d      <= sck_sync[SYNC_STAGES-1];
         nss_d      <= nss_sync[SYNC_STAGES-1];
         sck_rise_q <= sck_sync[SYNC_STAGES-1] & ~sck_d;
         sck_fall_q <= ~sck_sync[SYNC_STAGES-1] & sck_d;
         nss_rise_q <= nss_sync[SYNC_STAGES-1] & ~nss_d;
         nss_fall_q <= ~nss_sync[SYNC_STAGES-1] & nss_d;
         mosi_q     <= mosi_sync[SYNC_STAGES-1];
      end
   end

   // Frame control and edge classification from the latched mode
   assign abort       = ~en_i | nss_rise_q;
   assign start       = en_i & nss_fall_q;
   assign lead        = cpol_q ? sck_fall_q : sck_rise_q;
   assign trail       = cpol_q ? sck_rise_q : sck_fall_q;
   assign sample_edge = busy_o & (cpha_q ? trail : lead);
   assign shift_edge  = busy_o & (cpha_q ? lead : trail);
   assign lsb_c       = start ? lsb_i : lsb_q;
   assign dtb_c       = start ? dtb_i : dtb_q;

   // Word length and right-aligned RX mask
   always_comb begin
      n_bits  = BIT_CNT_W'(32);
      rx_mask = '1;
      case (dtb_c)
         2'd0: begin n_bits = BIT_CNT_W'(8);  rx_mask = SPI_DATA_WIDTH'(32'h0000_00FF); end
         2'd1: begin n_bits = BIT_CNT_W'(16); rx_mask = SPI_DATA_WIDTH'(32'h0000_FFFF); end
         2'd2: begin n_bits = BIT_CNT_W'(24); rx_mask = SPI_DATA_WIDTH'(32'h00FF_FFFF); end
         default: begin n_bits = BIT_CNT_W'(32); rx_mask = '1; end
      endcase
   end

   // Next-state for shift registers, bit counter, TX buffer and status
   always_comb begin
      tx_sh_n    = tx_sh;
      rx_sh_n    = rx_sh;
      bit_cnt_n  = bit_cnt;
      busy_n     = busy_o;
      rx_valid_n = rx_valid_o & ~rx_ready_i;
      rx_data_n  = rx_data_o;
      tx_buf_n   = tx_buf;
      tx_ready_n = tx_ready_o;
      ovr_n      = 1'b0;
      udr_n      = 1'b0;
      load_req   = 1'b0;

      if (abort) begin
         busy_n    = 1'b0;
         bit_cnt_n = '0;
         rx_sh_n   = '0;
         tx_sh_n   = '0;
      end else if (start) begin
         busy_n    = 1'b1;
         bit_cnt_n = '0;
         rx_sh_n   = '0;
         load_req  = 1'b1;
      end else if (sample_edge) begin
         if (lsb_q) begin
            rx_sh_n = rx_sh >> 1;
            rx_sh_n[IDX_W'(n_bits - BIT_CNT_W'(1))] = mosi_q;
         end else begin
            rx_sh_n = {rx_sh[SPI_DATA_WIDTH-2:0], mosi_q};
         end
         bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
         if (bit_cnt_n == n_bits) begin
            if (!rx_valid_o) begin
               rx_data_n  = rx_sh_n & rx_mask;
               rx_valid_n = 1'b1;
            end else begin
               ovr_n = 1'b1;
            end
         end
      end else if (shift_edge) begin
         if (bit_cnt == n_bits) begin
            load_req  = 1'b1;
            bit_cnt_n = '0;
         end else if (bit_cnt != '0) begin
            tx_sh_n = lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
         end
      end

      // Load from holding buffer; an empty buffer sends zeros and flags underrun
      if (load_req) begin
         if (!tx_ready_o) begin
            tx_sh_n    = tx_buf;
            tx_ready_n = 1'b1;
         end else begin
            tx_sh_n = '0;
            udr_n   = 1'b1;
         end
      end

      if (tx_valid_i && tx_ready_o) begin
         tx_buf_n   = tx_data_i;
         tx_ready_n = 1'b0;
      end

      miso_n = 1'b0;
      if (busy_n) begin
         miso_n = lsb_c ? tx_sh_n[0] : tx_sh_n[IDX_W'(n_bits - BIT_CNT_W'(1))];
      end
   end

   // State and registered outputs
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cpol_q        <= 1'b0;
         cpha_q        <= 1'b0;
         lsb_q         <= 1'b0;
         dtb_q         <= 2'd0;
         bit_cnt       <= '0;
         tx_sh         <= '0;
         rx_sh         <= '0;
         tx_buf        <= '0;
         tx_ready_o    <= 1'b1;
         rx_valid_o    <= 1'b0;
         rx_data_o     <= '0;
         busy_o        <= 1'b0;
         ovr_o         <= 1'b0;
         udr_o         <= 1'b0;
         spi_miso_o    <= 1'b0;
         spi_miso_oe_o <= 1'b0;
      end else begin
         if (start && !abort) begin
            cpol_q <= cpol_i;
            cpha_q <= cpha_i;
            lsb_q  <= lsb_i;
            dtb_q  <= dtb_i;
         end
         bit_cnt       <= bit_cnt_n;
         tx_sh         <= tx_sh_n;
         rx_sh         <= rx_sh_n;
         tx_buf        <= tx_buf_n;
         tx_ready_o    <= tx_ready_n;
         rx_valid_o    <= rx_valid_n;
         rx_data_o     <= rx_data_n;
         busy_o        <= busy_n;
         ovr_o         <= ovr_n;
         udr_o         <= udr_n;
         spi_miso_o    <= miso_n;
         spi_miso_oe_o <= busy_n;
      end
   end

endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: SPI master model, vector table and scoreboard for spi_slave_core.
module tb_spi_slave_core;
   import spi_slave_core_pkg::*;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int LAT  = SYNC_STAGES + 1;
   localparam int HALF = 10;

   logic        clk_i = 1'b0, rst_n_i = 1'b0, en_i = 1'b1;
   logic        cpol_i = 1'b0, cpha_i = 1'b0, lsb_i = 1'b0;
   logic [1:0]  dtb_i = 2'd0;
   logic        tx_valid_i = 1'b0, tx_ready_o;
   logic [31:0] tx_data_i = '0;
   logic        rx_valid_o, rx_ready_i = 1'b0;
   logic [31:0] rx_data_o;
   logic        busy_o, ovr_o, udr_o;
   logic        spi_sck_i = 1'b0, spi_nss_i = 1'b1, spi_mosi_i = 1'b0;
   logic        spi_miso_o, spi_miso_oe_o;

   spi_slave_core #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i),
      .cpol_i(cpol_i), .cpha_i(cpha_i), .lsb_i(lsb_i), .dtb_i(dtb_i),
      .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i),
      .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
      .busy_o(busy_o), .ovr_o(ovr_o), .udr_o(udr_o),
      .spi_sck_i(spi_sck_i), .spi_nss_i(spi_nss_i), .spi_mosi_i(spi_mosi_i),
      .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0, n_errors = 0;
   int cyc = 0, ovr_cnt = 0, udr_cnt = 0, rx_rise_cyc = 0, last_samp_cyc = 0;
   logic rxv_prev = 1'b0;
   logic [31:0] exp_rx_q[$];
   logic [31:0] exp_miso_q[$];

   typedef struct {
      logic        cpol, cpha, lsb;
      logic [1:0]  dtb;
      logic [31:0] tx, mosi, exp_rx, exp_miso;
   } vec_t;
   vec_t vecs[7];

   always @(posedge clk_i) cyc <= cyc + 1;

   // Pulse counters and rx_valid rise timestamp
   always @(negedge clk_i) begin
      if (ovr_o) ovr_cnt = ovr_cnt + 1;
      if (udr_o) udr_cnt = udr_cnt + 1;
      if (rx_valid_o && !rxv_prev) rx_rise_cyc = cyc;
      rxv_prev = rx_valid_o;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_tx_ready"}, tx_ready_o, 1);
      chk({tag, "_rx_valid"}, rx_valid_o, 0);
      chk({tag, "_rx_data"}, rx_data_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_ovr"}, ovr_o, 0);
      chk({tag, "_udr"}, udr_o, 0);
      chk({tag, "_miso"}, spi_miso_o, 0);
      chk({tag, "_oe"}, spi_miso_oe_o, 0);
   endtask

   task automatic write_tx(input logic [31:0] d);
      int t = 0;
      while (!tx_ready_o && t < 1000) begin
         tick(1);
         t++;
      end
      chk("tx_ready_wait", tx_ready_o, 1);
      tx_valid_i = 1'b1;
      tx_data_i  = d;
      tick(1);
      tx_valid_i = 1'b0;
   endtask

   task automatic set_mode(input logic cpol, input logic cpha, input logic lsb, input logic [1:0] dtb);
      cpol_i = cpol; cpha_i = cpha; lsb_i = lsb; dtb_i = dtb;
      spi_sck_i = cpol;
      tick(HALF);
   endtask

   task automatic nss_start();
      spi_nss_i = 1'b0;
      tick(HALF);
   endtask

   task automatic nss_end();
      tick(HALF);
      spi_nss_i = 1'b1;
      tick(HALF);
   endtask

   // Master transfers nbits of an n-bit word; returns the bits it sampled from MISO
   task automatic xfer(input int n, input int nbits, input logic [31:0] mosi_w, output logic [31:0] miso_w);
      miso_w = '0;
      for (int i = 0; i < nbits; i++) begin
         int idx = lsb_i ? i : n - 1 - i;
         if (!cpha_i) begin
            spi_mosi_i = mosi_w[idx];
            tick(HALF);
            spi_sck_i = ~cpol_i;
            last_samp_cyc = cyc;
            miso_w[idx] = spi_miso_o;
            tick(HALF);
            spi_sck_i = cpol_i;
         end else begin
            spi_sck_i = ~cpol_i;
            spi_mosi_i = mosi_w[idx];
            tick(HALF);
            spi_sck_i = cpol_i;
            last_samp_cyc = cyc;
            miso_w[idx] = spi_miso_o;
            tick(HALF);
         end
      end
   endtask

   // Wait for an RX word, compare it with the scoreboard head, then accept it
   task automatic expect_rx(input string name);
      int t = 0;
      logic [31:0] e;
      while (!rx_valid_o && t < 2000) begin
         tick(1);
         t++;
      end
      if (!rx_valid_o) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: rx_valid timeout got 0 expected 1", name);
      end else begin
         e = (exp_rx_q.size() != 0) ? exp_rx_q.pop_front() : 32'hxxxx_xxxx;
         chk(name, rx_data_o, e);
         rx_ready_i = 1'b1;
         tick(1);
         rx_ready_i = 1'b0;
         chk({name, "_clr"}, rx_valid_o, 0);
      end
   endtask

   task automatic chk_miso(input string name, input logic [31:0] got);
      logic [31:0] e;
      e = (exp_miso_q.size() != 0) ? exp_miso_q.pop_front() : 32'hxxxx_xxxx;
      chk(name, got, e);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] got;
      int n, u0, o0;

      vecs[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_11A5, 32'h0000_003C, 32'h0000_003C, 32'h0000_00A5};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 2'd3, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_BEEF, 32'h0000_1234, 32'h0000_1234, 32'h0000_BEEF};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 2'd2, 32'hFF5A_C30F, 32'h0081_7E24, 32'h0081_7E24, 32'h005A_C30F};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_0001, 32'h0000_0080, 32'h0000_0080, 32'h0000_0001};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 2'd3, 32'h8000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 2'd1, 32'hABCD_0180, 32'h0000_8001, 32'h0000_8001, 32'h0000_0180};

      tick(3);
      chk_reset("reset");
      rst_n_i = 1'b1;
      tick(5);

      // Table-driven single-word frames
      for (int v = 0; v < 7; v++) begin
         set_mode(vecs[v].cpol, vecs[v].cpha, vecs[v].lsb, vecs[v].dtb);
         n = 8 * (int'(vecs[v].dtb) + 1);
         write_tx(vecs[v].tx);
         exp_miso_q.push_back(vecs[v].exp_miso);
         exp_rx_q.push_back(vecs[v].exp_rx);
         u0 = udr_cnt;
         nss_start();
         chk($sformatf("v%0d_tx_ready_after_load", v), tx_ready_o, 1);
         chk($sformatf("v%0d_busy", v), busy_o, 1);
         chk($sformatf("v%0d_oe", v), spi_miso_oe_o, 1);
         chk($sformatf("v%0d_no_udr", v), udr_cnt - u0, 0);
         xfer(n, n, vecs[v].mosi, got);
         chk_miso($sformatf("v%0d_miso", v), got);
         nss_end();
         chk($sformatf("v%0d_busy_end", v), busy_o, 0);
         chk($sformatf("v%0d_oe_end", v), spi_miso_oe_o, 0);
         chk($sformatf("v%0d_miso_end", v), spi_miso_o, 0);
         expect_rx($sformatf("v%0d_rx", v));
         chk($sformatf("v%0d_rx_latency", v), rx_rise_cyc - last_samp_cyc, 1 + LAT);
      end

      // Overrun: mode 1, two 16-bit words under one NSS, RX not read
      set_mode(1'b0, 1'b1, 1'b0, 2'd1);
      write_tx(32'h0000_1111);
      exp_miso_q.push_back(32'h0000_1111);
      exp_miso_q.push_back(32'h0000_0000);
      exp_rx_q.push_back(32'h0000_CAFE);
      o0 = ovr_cnt;
      nss_start();
      xfer(16, 16, 32'h0000_CAFE, got);
      chk_miso("ovr_miso_w1", got);
      chk("ovr_none_yet", ovr_cnt - o0, 0);
      xfer(16, 16, 32'h0000_0F0F, got);
      chk_miso("ovr_miso_w2", got);
      tick(HALF);
      chk("ovr_pulse_count", ovr_cnt - o0, 1);
      chk("ovr_rx_held", rx_data_o, 32'h0000_CAFE);
      chk("ovr_rx_valid", rx_valid_o, 1);
      nss_end();
      expect_rx("ovr_rx");

      // Underrun: frame start with empty TX buffer
      set_mode(1'b1, 1'b1, 1'b0, 2'd0);
      chk("udr_buf_empty", tx_ready_o, 1);
      exp_miso_q.push_back(32'h0000_0000);
      exp_rx_q.push_back(32'h0000_0077);
      u0 = udr_cnt;
      nss_start();
      chk("udr_pulse_start", udr_cnt - u0, 1);
      xfer(8, 8, 32'h0000_0077, got);
      chk_miso("udr_miso_zero", got);
      nss_end();
      chk("udr_pulse_total", udr_cnt - u0, 1);
      chk("udr_tx_ready", tx_ready_o, 1);
      expect_rx("udr_rx");

      // Abort after 5 of 8 bits, then a full frame
      set_mode(1'b0, 1'b0, 1'b0, 2'd0);
      write_tx(32'h0000_0096);
      nss_start();
      xfer(8, 5, 32'h0000_00FF, got);
      tick(HALF);
      spi_nss_i = 1'b1;
      tick(LAT);
      chk("abort_busy_hold", busy_o, 1);
      tick(1);
      chk("abort_busy", busy_o, 0);
      chk("abort_oe", spi_miso_oe_o, 0);
      chk("abort_miso", spi_miso_o, 0);
      tick(HALF);
      chk("abort_rx_valid", rx_valid_o, 0);
      write_tx(32'h0000_0069);
      exp_miso_q.push_back(32'h0000_0069);
      exp_rx_q.push_back(32'h0000_00C3);
      nss_start();
      xfer(8, 8, 32'h0000_00C3, got);
      chk_miso("after_abort_miso", got);
      nss_end();
      expect_rx("after_abort_rx");

      // Async reset mid-frame, SCK activity ignored until a fresh NSS fall
      write_tx(32'h0000_005A);
      nss_start();
      write_tx(32'h0000_0033);
      xfer(8, 3, 32'h0000_00AA, got);
      tick(2);
      #3;
      rst_n_i = 1'b0;
      #1;
      chk_reset("rst_mid");
      @(negedge clk_i);
      rst_n_i = 1'b1;
      tick(2);
      xfer(8, 8, 32'h0000_00FF, got);
      tick(HALF);
      chk("rst_ignore_busy", busy_o, 0);
      chk("rst_ignore_oe", spi_miso_oe_o, 0);
      chk("rst_ignore_rx_valid", rx_valid_o, 0);
      spi_nss_i = 1'b1;
      tick(HALF);
      write_tx(32'h0000_00C6);
      exp_miso_q.push_back(32'h0000_00C6);
      exp_rx_q.push_back(32'h0000_0039);
      nss_start();
      xfer(8, 8, 32'h0000_0039, got);
      chk_miso("after_rst_miso", got);
      nss_end();
      expect_rx("after_rst_rx");

      chk("rx_queue_drained", exp_rx_q.size(), 0);
      chk("miso_queue_drained", exp_miso_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
